// File: rtl/slc3_io_pkg.sv
// slc3_io_pkg: shared types and defaults for the SLC3 board input conditioning.
// Holds the per-key debounce FSM state type, parameter defaults and a counter
// width helper used by the debouncer and the top-level conditioner.
package slc3_io_pkg;

    // Per-key debounce states; s is the synchronized key (0 = pressed)
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    // 10 ms at 50 MHz
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
    localparam int unsigned SYNC_STAGES_DEF     = 2;
    localparam int unsigned SW_WIDTH_DEF        = 10;
    // 0.5 s at 50 MHz
    localparam int unsigned REPEAT_CYCLES_DEF   = 25000000;

    // Counter width for a count that must reach n-1; never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/slc3_btn_debounce.sv
// slc3_btn_debounce: one raw active-low key -> synchronizer -> debounce FSM.
// Produces a registered active-high level and a one-cycle press pulse. When
// REPEAT_EN is set, the pulse also fires every REPEAT_CYCLES while the key
// remains held in PRESSED.
module slc3_btn_debounce
    import slc3_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEF,
    parameter bit          REPEAT_EN       = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_pulse,
    output logic o_level
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned RPT_W = cnt_width(REPEAT_CYCLES);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_ONE  = RPT_W'(1);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;

    btn_state_t             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [RPT_W-1:0]       r_rpt;
    logic                   r_pulse;
    logic                   r_level;

    // Synchronizer chain; resets to released so a held key is not seen as a new press
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_key_n};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // Debounce FSM with registered level/pulse; counters stop at their last value
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rpt   <= '0;
            r_pulse <= 1'b0;
            r_level <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            // Repeat counter only advances while PRESSED is held; cleared otherwise
            r_rpt   <= '0;
            case (r_state)
                IDLE: begin
                    if (!w_s) begin
                        r_state <= PRESS_WAIT;
                        r_cnt   <= CNT_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (w_s) begin
                        // Bounce: drop the candidate press silently
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= PRESSED;
                        r_cnt   <= '0;
                        r_pulse <= 1'b1;
                        r_level <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (w_s) begin
                        r_state <= RELEASE_WAIT;
                        r_cnt   <= CNT_ONE;
                    end else if (REPEAT_EN) begin
                        if (r_rpt == RPT_LAST) begin
                            r_pulse <= 1'b1;
                            r_rpt   <= '0;
                        end else begin
                            r_rpt <= r_rpt + RPT_ONE;
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (!w_s) begin
                        // Release glitch: still held, level never dropped
                        r_state <= PRESSED;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_level <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    assign o_pulse = r_pulse;
    assign o_level = r_level;

endmodule

// File: rtl/slc3_button_conditioner.sv
// slc3_button_conditioner: DE10-Lite input conditioning ahead of slc3_testtop.
// Debounces the active-low Run and Continue keys into clean levels and press
// pulses, and synchronizes the slide switches (no debouncing on switches).
// Optional feature macro: CONTINUE_AUTOREPEAT_EN -- when defined, holding
// Continue re-fires Continue_pulse every REPEAT_CYCLES cycles.
module slc3_button_conditioner
    import slc3_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int unsigned SW_WIDTH        = SW_WIDTH_DEF,
    parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                Run_n_raw,
    input  logic                Continue_n_raw,
    input  logic [SW_WIDTH-1:0] SW_raw,
    output logic                Run_pulse,
    output logic                Continue_pulse,
    output logic                Run_level,
    output logic                Continue_level,
    output logic [SW_WIDTH-1:0] SW_sync
);

`ifdef CONTINUE_AUTOREPEAT_EN
    localparam bit CONT_REPEAT_EN = 1'b1;
`else
    localparam bit CONT_REPEAT_EN = 1'b0;
`endif

    logic [SYNC_STAGES-1:0][SW_WIDTH-1:0] r_sw_sync;

    // Switch synchronizer: plain flop chain, latency SYNC_STAGES edges
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sw_sync <= '0;
        end else begin
            r_sw_sync <= {r_sw_sync[SYNC_STAGES-2:0], SW_raw};
        end
    end

    assign SW_sync = r_sw_sync[SYNC_STAGES-1];

    // Run never auto-repeats
    slc3_btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES),
        .REPEAT_CYCLES   (REPEAT_CYCLES),
        .REPEAT_EN       (1'b0)
    ) u_run_debounce (
        .i_clk   (Clk),
        .i_rst_n (Reset_n),
        .i_key_n (Run_n_raw),
        .o_pulse (Run_pulse),
        .o_level (Run_level)
    );

    slc3_btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES),
        .REPEAT_CYCLES   (REPEAT_CYCLES),
        .REPEAT_EN       (CONT_REPEAT_EN)
    ) u_continue_debounce (
        .i_clk   (Clk),
        .i_rst_n (Reset_n),
        .i_key_n (Continue_n_raw),
        .o_pulse (Continue_pulse),
        .o_level (Continue_level)
    );

endmodule
